// File: rtl/vga_scan_out_if.sv
// Pixel bus between the scan-out engine and the renderer / display side.
// The master (scan-out) publishes the current x/y and the registered VGA
// signals; the slave (renderer) answers with colour for that x/y.
interface vga_scan_out_if;
    logic [2:0] sprite_rgb;
    logic       sprite_valid;
    logic [2:0] bg_rgb;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] vga_rgb;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       vblank_tick;

    modport master (
        input  sprite_rgb, sprite_valid, bg_rgb,
        output x, y, vga_rgb, hsync, vsync, video_on, vblank_tick
    );

    modport slave (
        output sprite_rgb, sprite_valid, bg_rgb,
        input  x, y, vga_rgb, hsync, vsync, video_on, vblank_tick
    );
endinterface

// File: rtl/vga_scan_out.sv
// VGA scan-out: free-running h/v counters advanced by a pixel strobe, with
// colour, syncs, video_on and a vblank pulse registered one enabled cycle
// behind the x/y coordinates so they all stay mutually aligned.
// Handshake: there is no valid/ready flow control; pix_ce is a qualifier and
// every register holds its value while it is low. The renderer must present
// colour for the published x/y combinationally within the same pixel slot.
module vga_scan_out #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_ce,
    vga_scan_out_if.master vif
);
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [9:0] VB_H     = 10'(H_VIS - 1);
    localparam logic [9:0] VB_V     = 10'(V_VIS - 1);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [2:0] rgb_q, rgb_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_on_q, video_on_d;
    logic       vblank_q, vblank_d;
    logic       visible;

    // Visibility of the pixel the counters currently point at.
    assign visible = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);

    // Next-state: counters advance and outputs register only on pix_ce.
    always_comb begin
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        rgb_d      = rgb_q;
        hsync_d    = hsync_q;
        vsync_d    = vsync_q;
        video_on_d = video_on_q;
        vblank_d   = vblank_q;
        if (pix_ce) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            // Sprite wins over background; blanking forces black.
            if (!visible)
                rgb_d = 3'b000;
            else if (vif.sprite_valid)
                rgb_d = vif.sprite_rgb;
            else
                rgb_d = vif.bg_rgb;
            hsync_d    = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
            vsync_d    = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
            video_on_d = visible;
            vblank_d   = (h_cnt_q == VB_H) && (v_cnt_q == VB_V);
        end
    end

    // State registers with asynchronous reset to the idle/blank values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q    <= 10'd0;
            v_cnt_q    <= 10'd0;
            rgb_q      <= 3'b000;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b0;
            vblank_q   <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
            vblank_q   <= vblank_d;
        end
    end

    assign vif.x           = h_cnt_q;
    assign vif.y           = v_cnt_q;
    assign vif.vga_rgb     = rgb_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.video_on    = video_on_q;
    assign vif.vblank_tick = vblank_q;
endmodule

// File: tb/tb_vga_scan_out.sv
// Directed bench for vga_scan_out. d0 uses full 640x480 timing for line-level
// behaviour; d1 uses a shrunken 25x15 raster so whole frames, vsync, vblank
// and mid-frame reset fit in a short run with a 1-in-4 pixel strobe.
// Small raster: H 16/2/4/3 (total 25, hsync h=18..21),
//               V 8/2/2/3  (total 15, vsync v=10..11), frame 375 pixels.
module tb_vga_scan_out;
    logic clk;
    logic rst0, rst1;
    logic ce0, ce1;
    int   n_cmp;
    int   n_bad;
    int   e0, e1;
    int   lows, vb_cnt, vs_cnt;
    logic sp_en0;

    vga_scan_out_if if0 ();
    vga_scan_out_if if1 ();

    vga_scan_out d0 (
        .clk    (clk),
        .reset  (rst0),
        .pix_ce (ce0),
        .vif    (if0)
    );

    vga_scan_out #(
        .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VIS(8),  .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) d1 (
        .clk    (clk),
        .reset  (rst1),
        .pix_ce (ce1),
        .vif    (if1)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Renderer for d0: one opaque sprite pixel at (100,50), colour 110.
    always_comb begin
        if0.sprite_rgb   = 3'b110;
        if0.sprite_valid = sp_en0 && (if0.x == 10'd100) && (if0.y == 10'd50);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance d0 (pix_ce held high) until edge count reaches target, then settle.
    task automatic run0(input int target);
        while (e0 < target) begin
            @(posedge clk);
            e0++;
        end
        #2;
    endtask

    // Advance d1 with a 1-in-4 strobe; returns after the three frozen cycles.
    task automatic en1(input int target);
        while (e1 < target) begin
            ce1 = 1'b1;
            @(posedge clk);
            e1++;
            #2 ce1 = 1'b0;
            repeat (3) @(posedge clk);
            #2;
        end
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, "_x"},   {22'd0, if1.x},       32'd0);
        chk({tag, "_y"},   {22'd0, if1.y},       32'd0);
        chk({tag, "_rgb"}, {29'd0, if1.vga_rgb}, 32'd0);
        chk({tag, "_hs"},  {31'd0, if1.hsync},   32'd1);
        chk({tag, "_vs"},  {31'd0, if1.vsync},   32'd1);
        chk({tag, "_von"}, {31'd0, if1.video_on}, 32'd0);
        chk({tag, "_vbt"}, {31'd0, if1.vblank_tick}, 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; e0 = 0; e1 = 0;
        lows = 0; vb_cnt = 0; vs_cnt = 0;
        sp_en0 = 1'b0;
        rst0 = 1'b0; rst1 = 1'b0;
        ce0 = 1'b1; ce1 = 1'b0;
        if0.bg_rgb = 3'b001;
        if1.bg_rgb = 3'b101;
        if1.sprite_rgb = 3'b111;
        if1.sprite_valid = 1'b0;

        // Reset both units
        #1 rst0 = 1'b1; rst1 = 1'b1;
        #2;
        chk("d0_rst_x",   {22'd0, if0.x},        32'd0);
        chk("d0_rst_rgb", {29'd0, if0.vga_rgb},  32'd0);
        chk("d0_rst_hs",  {31'd0, if0.hsync},    32'd1);
        chk("d0_rst_vs",  {31'd0, if0.vsync},    32'd1);
        chk("d0_rst_von", {31'd0, if0.video_on}, 32'd0);
        chk_reset1("d1_rst");
        repeat (2) @(posedge clk);
        #2 rst0 = 1'b0;

        // d0: first pixel, end of visible line, hsync window
        run0(1);
        chk("d0_c1_rgb", {29'd0, if0.vga_rgb},  32'h1);
        chk("d0_c1_von", {31'd0, if0.video_on}, 32'd1);
        chk("d0_c1_x",   {22'd0, if0.x},        32'd1);
        chk("d0_c1_hs",  {31'd0, if0.hsync},    32'd1);
        run0(640);
        chk("d0_c640_rgb", {29'd0, if0.vga_rgb}, 32'h1);
        run0(641);
        chk("d0_c641_rgb", {29'd0, if0.vga_rgb},  32'h0);
        chk("d0_c641_von", {31'd0, if0.video_on}, 32'd0);
        run0(656);
        chk("d0_hs_pre",   {31'd0, if0.hsync}, 32'd1);
        run0(657);
        chk("d0_hs_first", {31'd0, if0.hsync}, 32'd0);
        run0(752);
        chk("d0_hs_last",  {31'd0, if0.hsync}, 32'd0);
        run0(753);
        chk("d0_hs_post",  {31'd0, if0.hsync}, 32'd1);
        run0(800);
        chk("d0_wrap_x", {22'd0, if0.x}, 32'd0);
        chk("d0_wrap_y", {22'd0, if0.y}, 32'd1);

        // d0: count hsync-low cycles over one full line
        for (int k = 0; k < 800; k++) begin
            @(posedge clk);
            e0++;
            #2;
            if (if0.hsync == 1'b0) lows++;
        end
        chk("d0_hs_width", lows, 32'd96);
        chk("d0_line_x", {22'd0, if0.x}, 32'd0);
        chk("d0_line_y", {22'd0, if0.y}, 32'd2);

        // d0: sprite pixel at (100,50) over bg 010
        if0.bg_rgb = 3'b010;
        sp_en0 = 1'b1;
        run0(50 * 800 + 100);
        chk("d0_spr_left",  {29'd0, if0.vga_rgb}, 32'h2);
        run0(50 * 800 + 101);
        chk("d0_spr_hit",   {29'd0, if0.vga_rgb}, 32'h6);
        chk("d0_spr_x",     {22'd0, if0.x},       32'd101);
        chk("d0_spr_y",     {22'd0, if0.y},       32'd50);
        run0(50 * 800 + 102);
        chk("d0_spr_right", {29'd0, if0.vga_rgb}, 32'h2);
        ce0 = 1'b0;

        // d1: release reset, run one full frame at a 1-in-4 strobe
        #2 rst1 = 1'b0;
        for (int k = 1; k <= 375; k++) begin
            en1(k);
            if (if1.vblank_tick) vb_cnt++;
            if (!if1.vsync) vs_cnt++;
            case (k)
                1: begin
                    chk("d1_c1_x",   {22'd0, if1.x},        32'd1);
                    chk("d1_c1_y",   {22'd0, if1.y},        32'd0);
                    chk("d1_c1_rgb", {29'd0, if1.vga_rgb},  32'h5);
                    chk("d1_c1_von", {31'd0, if1.video_on}, 32'd1);
                end
                16: chk("d1_last_vis", {29'd0, if1.vga_rgb}, 32'h5);
                17: chk("d1_first_blank", {31'd0, if1.video_on}, 32'd0);
                18: chk("d1_hs_pre",   {31'd0, if1.hsync}, 32'd1);
                19: chk("d1_hs_first", {31'd0, if1.hsync}, 32'd0);
                22: chk("d1_hs_last",  {31'd0, if1.hsync}, 32'd0);
                23: chk("d1_hs_post",  {31'd0, if1.hsync}, 32'd1);
                190: chk("d1_vbt_pre",  {31'd0, if1.vblank_tick}, 32'd0);
                191: chk("d1_vbt_hit",  {31'd0, if1.vblank_tick}, 32'd1);
                192: chk("d1_vbt_post", {31'd0, if1.vblank_tick}, 32'd0);
                250: chk("d1_vs_pre",   {31'd0, if1.vsync}, 32'd1);
                251: chk("d1_vs_first", {31'd0, if1.vsync}, 32'd0);
                300: chk("d1_vs_last",  {31'd0, if1.vsync}, 32'd0);
                301: chk("d1_vs_post",  {31'd0, if1.vsync}, 32'd1);
                374: begin
                    chk("d1_end_x", {22'd0, if1.x}, 32'd24);
                    chk("d1_end_y", {22'd0, if1.y}, 32'd14);
                end
                375: begin
                    chk("d1_wrap_x", {22'd0, if1.x}, 32'd0);
                    chk("d1_wrap_y", {22'd0, if1.y}, 32'd0);
                end
                default: ;
            endcase
        end
        chk("d1_vbt_count", vb_cnt, 32'd1);
        chk("d1_vs_width",  vs_cnt, 32'd50);

        // d1: reset in the middle of the vsync pulse of frame 2
        en1(375 + 251);
        chk("d1_mid_vs", {31'd0, if1.vsync}, 32'd0);
        chk("d1_mid_y",  {22'd0, if1.y},     32'd10);
        rst1 = 1'b1;
        #1;
        chk_reset1("d1_async");
        ce1 = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk_reset1("d1_held");
        ce1 = 1'b0;
        rst1 = 1'b0;
        e1 = 0;
        en1(1);
        chk("d1_rel_x",   {22'd0, if1.x},        32'd1);
        chk("d1_rel_y",   {22'd0, if1.y},        32'd0);
        chk("d1_rel_rgb", {29'd0, if1.vga_rgb},  32'h5);
        chk("d1_rel_von", {31'd0, if1.video_on}, 32'd1);
        chk("d1_rel_vs",  {31'd0, if1.vsync},    32'd1);
        chk("d1_rel_hs",  {31'd0, if1.hsync},    32'd1);
        en1(18);
        chk("d1_rel_hs_pre",   {31'd0, if1.hsync}, 32'd1);
        en1(19);
        chk("d1_rel_hs_first", {31'd0, if1.hsync}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_scan_out.md
VGA_SCAN_OUT -- requirements
Module: vga_scan_out

Interface
REQ-001 Parameters SHALL be: H_VIS 640 (visible columns); H_FP 16 (horizontal front porch); H_SYNC 96 (hsync width); H_BP 48 (horizontal back porch); V_VIS 480 (visible rows); V_FP 10 (vertical front porch); V_SYNC 2 (vsync width); V_BP 33 (vertical back porch).
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 pix_ce  input  1  pixel-rate enable (e.g. 25 MHz strobe); all state advances only when high.
REQ-005 sprite_rgb  input  3  sprite colour from renderer, combinational in x/y.
REQ-006 sprite_valid  input  1  sprite pixel opaque at current x/y.
REQ-007 bg_rgb  input  3  background colour for current x/y.
REQ-008 x  output  10  current horizontal count, driven directly from h_cnt register.
REQ-009 y  output  10  current vertical count, driven directly from v_cnt register.
REQ-010 vga_rgb  output  3  registered pixel colour {R,G,B}.
REQ-011 hsync  output  1  registered, active-low.
REQ-012 vsync  output  1  registered, active-low.
REQ-013 video_on  output  1  registered, high while vga_rgb is a visible pixel.
REQ-014 vblank_tick  output  1  registered one-pixel pulse at start of vertical blanking.

Function
REQ-015 H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525).
REQ-016 When pix_ce=1, h_cnt SHALL increment; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
REQ-017 v_cnt SHALL wrap from V_TOTAL-1 to 0 only when h_cnt wraps; frame = 800x525 = 420000 enabled cycles.
REQ-018 When pix_ce=0, every register (counters and all outputs) SHALL hold its value.
REQ-019 visible = (h_cnt < H_VIS) && (v_cnt < V_VIS), evaluated on current counters.
REQ-020 On each enabled edge: vga_rgb <= visible ? (sprite_valid ? sprite_rgb : bg_rgb) : 3'b000.
REQ-021 Sprite SHALL take priority over background; sprite_rgb SHALL be ignored when sprite_valid=0.
REQ-022 hsync <= 0 iff h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656,751], else 1.
REQ-023 vsync <= 0 iff v_cnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] = [490,491], else 1.
REQ-024 video_on <= visible.
REQ-025 Latency: vga_rgb, hsync, vsync and video_on SHALL lag x/y by exactly one enabled cycle, so all four stay mutually aligned.
REQ-026 vblank_tick <= 1 for exactly one enabled cycle, on the edge where (h_cnt,v_cnt) = (H_VIS-1, V_VIS-1); otherwise 0.
REQ-027 vblank_tick SHALL remain high while pix_ce=0 holds it (per REQ-018); consumers qualify it with pix_ce.
REQ-028 x/y SHALL count through blanking (x up to 799, y up to 524); downstream renderers tolerate out-of-range coordinates.
REQ-029 No combinational path SHALL exist from sprite_*/bg_rgb to any output.

Reset
REQ-030 While reset=1, asynchronously: h_cnt=0, v_cnt=0, vga_rgb=000, hsync=1, vsync=1, video_on=0, vblank_tick=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; after release, scanning restarts at (0,0) on the first enabled edge with no partial sync pulse.
REQ-032 The first enabled edge after reset SHALL register pixel (0,0).

Verification
REQ-033 Reset release with pix_ce=1 constant, bg_rgb=001, sprite_valid=0 -> at cycle 1 vga_rgb=001 and video_on=1; at cycle 641 vga_rgb=000 and video_on=0.
REQ-034 Free-run one line -> hsync low for exactly 96 cycles, first low cycle registered from h_cnt=656; line period 800; vsync low for exactly 1600 cycles per frame, starting at v_cnt=490.
REQ-035 sprite_valid=1 with sprite_rgb=110 only at (100,50), bg_rgb=010 -> vga_rgb=110 one cycle after x=100,y=50; vga_rgb=010 at neighbouring pixels.
REQ-036 pix_ce toggling 1/0 (1 of 4) -> counters and outputs frozen on pix_ce=0 cycles; frame = 420000 enabled cycles; waveform identical to continuous run after decimation.
REQ-037 Full frame run -> exactly one vblank_tick pulse per 420000 enabled cycles, registered from (639,479); x wraps 799->0, y wraps 524->0.
REQ-038 Assert reset at (300,200) mid-frame, release -> all outputs at reset values during reset; first enabled edge registers (0,0); hsync/vsync high until their regular windows.
